// File: rtl/ctech_lib_hs_rx_sync_pkg.sv
// Shared types and limits for the ctech four-phase handshake receiver and its synchronizer.
package ctech_lib_hs_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        WAIT_REL = 2'd2
    } hs_rx_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic bit sync_stages_ok(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/ctech_lib_hs_rx_sync_if.sv
// Bundle between the foreign-domain sender / local consumer and the handshake receiver.
interface ctech_lib_hs_rx_sync_if #(
    parameter int WIDTH = 8
);
    logic             req_async;
    logic [WIDTH-1:0] data_async;
    logic             ack;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             i_ready;
    logic             o_busy;
    logic             o_proto_err;

    // master: sender plus local consumer; slave: the receiver block
    modport master (
        output req_async, data_async, i_ready,
        input  ack, o_valid, o_data, o_busy, o_proto_err
    );

    modport slave (
        input  req_async, data_async, i_ready,
        output ack, o_valid, o_data, o_busy, o_proto_err
    );
endinterface

// File: rtl/ctech_lib_hs_sync.sv
// Plain 1-bit async-reset synchronizer chain; also used by the sender side for its ack.
module ctech_lib_hs_sync
    import ctech_lib_hs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("ctech_lib_hs_sync: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] chain;

    // No logic between stages so each flop has a full cycle to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ctech_lib_hs_rx_sync.sv
// Receiving end of a four-phase req/ack crossing: synchronizes req, captures the held word,
// offers it as a valid/ready stream and returns a registered ack.
module ctech_lib_hs_rx_sync
    import ctech_lib_hs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ctech_lib_hs_rx_sync_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("ctech_lib_hs_rx_sync: WIDTH out of range");
    end

    logic             req_s;
    hs_rx_state_e     state;
    logic             ack_q;
    logic             valid_q;
    logic             busy_q;
    logic             err_q;
    logic [WIDTH-1:0] data_q;

    ctech_lib_hs_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.req_async),
        .q   (req_s)
    );

    // data_async is only sampled once req_s is seen, when the sender guarantees it is stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_s) begin
                        data_q  <= bus.data_async;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // req dropping before ack is flagged but the word is still delivered
                    if (!req_s) err_q <= 1'b1;
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        state   <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!req_s) begin
                        ack_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_proto_err = err_q;

endmodule

// File: tb/tb_ctech_lib_hs_rx_sync.sv
// Bench for ctech_lib_hs_rx_sync: directed vector table on a 2-stage instance, then
// randomized sender/consumer traffic on 2- and 4-stage instances against a word queue.
module tb_ctech_lib_hs_rx_sync;

    localparam int NWORDS = 200;

    logic clk;
    logic rst;

    logic       d_req, d_rdy;
    logic [7:0] d_data;
    bit         rand_mode;
    bit         rand_go;

    logic       w_valid [2];
    logic       w_ack   [2];
    logic       w_busy  [2];
    logic       w_err   [2];
    logic [7:0] w_data  [2];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int STAGES = (g == 0) ? 2 : 4;

        logic       r_req, r_rdy;
        logic [7:0] r_data;
        logic [7:0] exp_q[$];
        bit         snd_done;
        bit         done_f;
        int         got;

        ctech_lib_hs_rx_sync_if #(.WIDTH(8)) bus ();

        ctech_lib_hs_rx_sync #(
            .WIDTH       (8),
            .SYNC_STAGES (STAGES)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.req_async  = (g == 0 && !rand_mode) ? d_req  : r_req;
        assign bus.data_async = (g == 0 && !rand_mode) ? d_data : r_data;
        assign bus.i_ready    = (g == 0 && !rand_mode) ? d_rdy  : r_rdy;
        assign w_valid[g] = bus.o_valid;
        assign w_ack[g]   = bus.ack;
        assign w_busy[g]  = bus.o_busy;
        assign w_err[g]   = bus.o_proto_err;
        assign w_data[g]  = bus.o_data;

        // Foreign-domain sender: polls ack on even ns, never coincident with clk rises
        initial begin : sender
            int t;
            r_req = 1'b0;
            r_data = 8'h00;
            snd_done = 1'b0;
            wait (rand_go);
            for (int n = 0; n < NWORDS; n++) begin
                repeat ($urandom_range(0, 5)) #2;
                r_data = 8'($urandom);
                exp_q.push_back(r_data);
                r_req = 1'b1;
                t = 0;
                while (w_ack[g] !== 1'b1 && t < 2000) begin #2; t++; end
                chk($sformatf("ack_rise_s%0d", STAGES), 64'(t < 2000), 64'd1);
                r_req = 1'b0;
                t = 0;
                while (w_ack[g] !== 1'b0 && t < 2000) begin #2; t++; end
                chk($sformatf("ack_fall_s%0d", STAGES), 64'(t < 2000), 64'd1);
            end
            snd_done = 1'b1;
        end

        // Local consumer: a word moves when o_valid and the ready it drives meet at a rise
        initial begin : consumer
            int cyc;
            r_rdy = 1'b0;
            got = 0;
            done_f = 1'b0;
            cyc = 0;
            wait (rand_go);
            while (!(snd_done && exp_q.size() == 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                r_rdy = ($urandom_range(0, 3) != 0);
                if (w_valid[g] === 1'b1 && r_rdy) begin
                    got++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("dup_word_s%0d", STAGES), 64'(w_data[g]), 64'hDEAD);
                    end else begin
                        chk($sformatf("word_s%0d", STAGES), 64'(w_data[g]), 64'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                end
            end
            r_rdy = 1'b0;
            done_f = 1'b1;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         hold;
        bit         early_rdy;
        int         exp_lat;
        int         exp_rel;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit ok;
        d_data = v.data;
        d_req  = 1'b1;
        d_rdy  = v.early_rdy;
        lat = 0;
        do begin tick(); lat++; end while (w_valid[0] !== 1'b1 && lat < 10);
        chk($sformatf("v%0d_cap_lat", idx), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d_data", idx), 64'(w_data[0]), 64'(v.data));
        chk($sformatf("v%0d_busy", idx), 64'(w_busy[0]), 64'd1);
        ok = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            tick();
            if (w_valid[0] !== 1'b1 || w_data[0] !== v.data || w_ack[0] !== 1'b0) ok = 1'b0;
        end
        chk($sformatf("v%0d_hold_stable", idx), 64'(ok), 64'd1);
        d_rdy = 1'b1;
        tick();
        chk($sformatf("v%0d_ack_on_accept", idx), {w_valid[0], w_ack[0]}, 64'b01);
        d_rdy = 1'b0;
        d_req = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (w_ack[0] !== 1'b0 && lat < 10);
        chk($sformatf("v%0d_rel_lat", idx), 64'(lat), 64'(v.exp_rel));
        chk($sformatf("v%0d_idle", idx), 64'(w_busy[0]), 64'd0);
        chk($sformatf("v%0d_data_held", idx), 64'(w_data[0]), 64'(v.data));
    endtask

    initial begin
        int lat;
        vecs[0] = '{data: 8'hA5, hold: 0,  early_rdy: 1'b1, exp_lat: 3, exp_rel: 3};
        vecs[1] = '{data: 8'h3C, hold: 10, early_rdy: 1'b0, exp_lat: 3, exp_rel: 3};
        vecs[2] = '{data: 8'h5A, hold: 0,  early_rdy: 1'b1, exp_lat: 3, exp_rel: 3};
        vecs[3] = '{data: 8'h00, hold: 2,  early_rdy: 1'b0, exp_lat: 3, exp_rel: 3};
        vecs[4] = '{data: 8'hFF, hold: 1,  early_rdy: 1'b0, exp_lat: 3, exp_rel: 3};

        rst = 1'b1;
        d_req = 1'b0;
        d_rdy = 1'b0;
        d_data = 8'h00;
        rand_mode = 1'b0;
        rand_go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   64'(w_ack[0]),   64'd0);
        chk("rst_valid", 64'(w_valid[0]), 64'd0);
        chk("rst_data",  64'(w_data[0]),  64'd0);
        chk("rst_busy",  64'(w_busy[0]),  64'd0);
        chk("rst_err",   64'(w_err[0]),   64'd0);
        rst = 1'b0;
        tick();
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);
        chk("no_err_after_vecs", 64'(w_err[0]), 64'd0);

        // req withdrawn while the word is still waiting for ready
        d_data = 8'h77;
        d_req  = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (w_valid[0] !== 1'b1 && lat < 10);
        chk("perr_cap_lat", 64'(lat), 64'd3);
        d_req = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (w_err[0] !== 1'b1 && lat < 6);
        chk("perr_set", 64'(w_err[0]), 64'd1);
        chk("perr_word_kept", {w_valid[0], w_ack[0], w_data[0]}, {1'b1, 1'b0, 8'h77});
        d_rdy = 1'b1;
        tick();
        chk("perr_ack_pulse", {w_valid[0], w_ack[0]}, 64'b01);
        d_rdy = 1'b0;
        tick();
        chk("perr_ack_drop", {w_ack[0], w_busy[0], w_err[0]}, 64'b001);
        run_vec('{data: 8'h96, hold: 0, early_rdy: 1'b1, exp_lat: 3, exp_rel: 3}, 9);
        chk("perr_sticky", 64'(w_err[0]), 64'd1);

        // async reset while ack is high
        d_data = 8'hC3;
        d_req  = 1'b1;
        lat = 0;
        do begin tick(); lat++; end while (w_valid[0] !== 1'b1 && lat < 10);
        d_rdy = 1'b1;
        tick();
        chk("mrst_pre_ack", 64'(w_ack[0]), 64'd1);
        d_rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_async", {w_ack[0], w_valid[0], w_busy[0], w_err[0], w_data[0]}, 64'd0);
        #1;
        rst = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (w_valid[0] !== 1'b1 && lat < 10);
        chk("mrst_recap_lat", 64'(lat), 64'd3);
        chk("mrst_recap_data", 64'(w_data[0]), 64'hC3);
        d_rdy = 1'b1;
        tick();
        d_rdy = 1'b0;
        d_req = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (w_ack[0] !== 1'b0 && lat < 10);
        chk("mrst_release", {w_ack[0], w_busy[0]}, 64'd0);

        rand_mode = 1'b1;
        rand_go = 1'b1;
        lat = 0;
        while (!(g_dut[0].done_f && g_dut[1].done_f) && lat < 30000) begin
            @(posedge clk);
            lat++;
        end
        #1;
        chk("rand_done", 64'(g_dut[0].done_f && g_dut[1].done_f), 64'd1);
        chk("rand_count_s2", 64'(g_dut[0].got), 64'(NWORDS));
        chk("rand_count_s4", 64'(g_dut[1].got), 64'(NWORDS));
        chk("rand_left_s2", 64'(g_dut[0].exp_q.size()), 64'd0);
        chk("rand_left_s4", 64'(g_dut[1].exp_q.size()), 64'd0);
        chk("rand_err_s2", 64'(w_err[0]), 64'd0);
        chk("rand_err_s4", 64'(w_err[1]), 64'd0);
        chk("rand_idle", {w_busy[0], w_busy[1], w_ack[0], w_ack[1]}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctech_lib_hs_rx_sync.md
# ctech_lib_hs_rx_sync

Receiving end of a four-phase req/ack handshake that carries a WIDTH-bit word across a clock-domain boundary into the local `clk` domain. It synchronizes the incoming asynchronous request, captures the sender-held data word, presents it locally as a valid/ready stream, and returns a registered acknowledge to the sender. It sits with the ctech library primitives, paired with a sender-side block in the foreign domain, and is the standard way data words enter a domain.

## Interface
- WIDTH, default 8: data word width, 1..64.
- SYNC_STAGES, default 2: flops in the req synchronizer chain, 2..4.

- clk  in  1  local clock.
- rst  in  1  asynchronous, active-high reset.
- req_async  in  1  sender request, asynchronous to `clk`.
- data_async  in  WIDTH  sender data; stable from req rise until ack rise (sender contract).
- ack  out  1  registered acknowledge back to sender.
- o_valid  out  WIDTH-less, 1  local word valid.
- o_data  out  WIDTH  captured word.
- i_ready  in  1  local consumer ready.
- o_busy  out  1  high whenever state != IDLE.
- o_proto_err  out  1  sticky: req fell before ack rose.

## Operation
- `req_s` is the output of a SYNC_STAGES-deep flop chain on `req_async`, reset to 0. All control uses only `req_s`.
- FSM states:
  - IDLE: ack=0, o_valid=0. If `req_s`=1, then `data_q`<=`data_async`, o_valid<=1, go to WAIT_RDY.
  - WAIT_RDY: o_valid=1, `o_data` held. If `i_ready`=1, then o_valid<=0, ack<=1, go to WAIT_REL.
  - WAIT_REL: ack=1. If `req_s`=0, then ack<=0, go to IDLE.
- Transfer completes on a clock edge where o_valid & i_ready.
- `o_data` changes only on capture and holds its value in all other states, including after the transfer.
- Protocol violation: `req_s`=0 while in WAIT_RDY.
  - o_proto_err<=1. It clears only on rst.
  - The word is still delivered normally. The FSM then passes through WAIT_REL for exactly one cycle and drops ack.
- A new request is never sampled outside IDLE. A req rise seen in WAIT_REL is ignored until ack has dropped and the FSM is back in IDLE.
- All outputs are registered. Nothing is combinational from `i_ready`, `req_async` or `data_async` to any output.

## Timing
- Reset values, applied asynchronously on rst=1: state=IDLE, sync chain=0, ack=0, o_valid=0, o_data=0, o_busy=0, o_proto_err=0.
- Reset mid-transfer discards the held word. The sender then sees ack=0 and must restart its own handshake.
- Latency from req_async rise to o_valid=1: SYNC_STAGES+1 clk edges, counting the first edge that samples req high. With defaults this is 3.
- Latency from the accept edge (valid & ready) to ack=1: same edge, ack visible after it.
- Latency from req_async fall to ack=0: SYNC_STAGES+1 edges.
- Back-to-back throughput: one word per at least 2·(SYNC_STAGES+1) local cycles, plus the sender's own sync delay.
- `i_ready` may be held high permanently. o_valid then stays high for exactly 1 cycle per word.
- `o_busy` is registered alongside the state, so it is high in exactly the cycles where state != IDLE.

## Structure
- Package `ctech_lib_hs_pkg` holds:
  - `hs_rx_state_e`: IDLE, WAIT_RDY, WAIT_REL, 2-bit encoding.
  - Limits SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4. These are checked by an elaboration-time assertion.
- One sub-module, `ctech_lib_hs_sync`, parameterized by SYNC_STAGES: a 1-bit async-reset flop chain with no logic between stages. The sender block reuses it for its ack synchronizer.

## Test plan
- Reset, then req_async=1 with data_async=8'hA5 and i_ready=1 → o_valid=1 with o_data=8'hA5 exactly 3 edges later, for 1 cycle. ack=1 on the same edge that o_valid falls.
- i_ready=0 for 10 cycles after capture → o_valid and o_data=8'h3C stay stable and ack stays 0. Raising i_ready → ack=1 on the next edge.
- Drop req_async after ack=1 → ack=0 three edges later and o_busy=0. A new req with 8'h5A is then captured and delivered.
- Drop req_async while in WAIT_RDY → o_proto_err=1 and stays 1. The word is still delivered on i_ready, and ack pulses high for 1 cycle.
- Assert rst in WAIT_REL (ack=1) → ack, o_valid, o_busy and o_data go to 0 immediately, without waiting for an edge. After release with req still high, the word is re-captured after 3 edges.
- 200 random back-to-back words with random i_ready, sender-model driven, at SYNC_STAGES=2 and 4 → no loss, no duplication, order preserved, o_proto_err=0.
